// File: rtl/gpio_seqr_if.sv
// Wishbone slave bus bundle for gpio_seqr; signal names keep the original
// port names so existing connections map one-to-one.
interface gpio_seqr_if;
   logic        i_wb_cyc;
   logic        i_wb_stb;
   logic        i_wb_we;
   logic [1:0]  i_wb_addr;
   logic [31:0] i_wb_data;
   logic        o_wb_ack;
   logic        o_wb_stall;
   logic [31:0] o_wb_data;

   modport master (
      output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
      input  o_wb_ack, o_wb_stall, o_wb_data
   );

   modport slave (
      input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
      output o_wb_ack, o_wb_stall, o_wb_data
   );
endinterface

// File: rtl/gpio_seqr.sv
// Programmable GPIO output sequencer: plays (word, hold) steps as timed write
// strobes. Optional external trigger/arm support under GPIOSEQ_TRIGGER_EN.
module gpio_seqr #(
   parameter int unsigned LGDEPTH = 4,
   parameter int unsigned HOLDW   = 16
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   gpio_seqr_if.slave  wb,
   output logic        o_gpio_stb,
   output logic [31:0] o_gpio_data,
   output logic        o_int
`ifdef GPIOSEQ_TRIGGER_EN
   ,
   input  logic        i_trig
`endif
);

   localparam int unsigned DEPTH = 2**LGDEPTH;
   localparam int unsigned LW    = LGDEPTH + 1;

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WRITE, S_HOLD} state_t;

   state_t               r_state, w_next;
   logic [LW-1:0]        r_len;
   logic [LGDEPTH-1:0]   r_wptr, r_step;
   logic                 r_loop, r_done, r_int, r_ack;
   logic [31:0]          r_rdata, r_stage, r_rd_word;
   logic [HOLDW-1:0]     r_last_hold, r_rd_hold, r_cnt;
   logic [31:0]          r_mem_word [DEPTH];
   logic [HOLDW-1:0]     r_mem_hold [DEPTH];

   logic        w_wr, w_busy, w_ctrl_wr, w_abort, w_start_req, w_go;
   logic        w_cfg_wr, w_commit, w_last, w_decide, w_finish;
   logic        w_trig_go, w_armed, w_gpio_stb;
   logic [31:0] w_rdata;

   assign w_wr        = wb.i_wb_cyc & wb.i_wb_stb & wb.i_wb_we;
   assign w_busy      = (r_state != S_IDLE);
   assign w_ctrl_wr   = w_wr && (wb.i_wb_addr == 2'd0);
   assign w_abort     = w_ctrl_wr & wb.i_wb_data[1];
   assign w_start_req = (w_ctrl_wr & wb.i_wb_data[0]) | w_trig_go;
   assign w_go        = w_start_req & ~w_abort & ~w_busy & (r_len != '0);
   assign w_cfg_wr    = w_wr & ~w_busy;
   assign w_commit    = w_cfg_wr && (wb.i_wb_addr == 2'd3);
   assign w_last      = ({1'b0, r_step} == (r_len - LW'(1)));
   assign w_decide    = ((r_state == S_WRITE) && (r_rd_hold == '0)) ||
                        ((r_state == S_HOLD)  && (r_cnt == HOLDW'(1)));
   assign w_finish    = w_decide & w_last & ~r_loop & ~w_abort;

`ifdef GPIOSEQ_TRIGGER_EN
   logic r_trig_s1, r_trig_s2, r_trig_s3, r_armed;

   assign w_trig_go = r_trig_s2 & ~r_trig_s3 & r_armed;
   assign w_armed   = r_armed;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_trig_s1 <= 1'b0;
         r_trig_s2 <= 1'b0;
         r_trig_s3 <= 1'b0;
         r_armed   <= 1'b0;
      end else begin
         r_trig_s1 <= i_trig;
         r_trig_s2 <= r_trig_s1;
         r_trig_s3 <= r_trig_s2;
         if (w_abort || w_trig_go)
            r_armed <= 1'b0;
         else if (w_ctrl_wr && wb.i_wb_data[3] && !w_busy && (r_len != '0))
            r_armed <= 1'b1;
      end
   end
`else
   assign w_trig_go = 1'b0;
   assign w_armed   = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) r_state <= S_IDLE;
      else            r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (w_abort)
         w_next = S_IDLE;
      else begin
         case (r_state)
            S_IDLE:  if (w_go) w_next = S_FETCH;
            S_FETCH: w_next = S_WRITE;
            S_WRITE: w_next = (r_rd_hold == '0) ? ((w_last && !r_loop) ? S_IDLE : S_FETCH)
                                                : S_HOLD;
            S_HOLD:  if (r_cnt == HOLDW'(1))
                        w_next = (w_last && !r_loop) ? S_IDLE : S_FETCH;
            default: w_next = S_IDLE;
         endcase
      end
   end

   always_comb begin
      w_gpio_stb = (r_state == S_WRITE);
   end

   // Program RAM has no reset; contents survive a reset of the control logic.
   always_ff @(posedge i_clk) begin
      if (w_commit) begin
         r_mem_word[r_wptr] <= r_stage;
         r_mem_hold[r_wptr] <= wb.i_wb_data[HOLDW-1:0];
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_step    <= '0;
         r_done    <= 1'b0;
         r_int     <= 1'b0;
         r_rd_word <= '0;
         r_rd_hold <= '0;
         r_cnt     <= '0;
      end else begin
         r_int <= w_finish;
         if (w_go) begin
            r_step <= '0;
            r_done <= 1'b0;
         end else if (w_decide && !w_abort) begin
            if (!w_last)    r_step <= r_step + LGDEPTH'(1);
            else if (r_loop) r_step <= '0;
            else            r_done <= 1'b1;
         end
         if (r_state == S_FETCH) begin
            r_rd_word <= r_mem_word[r_step];
            r_rd_hold <= r_mem_hold[r_step];
         end
         if (r_state == S_WRITE)     r_cnt <= r_rd_hold;
         else if (r_state == S_HOLD) r_cnt <= r_cnt - HOLDW'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_len       <= '0;
         r_wptr      <= '0;
         r_loop      <= 1'b0;
         r_stage     <= '0;
         r_last_hold <= '0;
      end else begin
         if (w_ctrl_wr) r_loop <= wb.i_wb_data[2];
         if (w_cfg_wr) begin
            case (wb.i_wb_addr)
               2'd1: begin
                  r_len  <= (wb.i_wb_data > 32'(DEPTH)) ? LW'(DEPTH) : wb.i_wb_data[LW-1:0];
                  r_wptr <= '0;
               end
               2'd2: r_stage <= wb.i_wb_data;
               2'd3: begin
                  r_last_hold <= wb.i_wb_data[HOLDW-1:0];
                  r_wptr      <= r_wptr + LGDEPTH'(1);
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      w_rdata = '0;
      case (wb.i_wb_addr)
         2'd0: begin
            w_rdata[31]              = w_busy;
            w_rdata[30]              = r_done;
            w_rdata[29]              = r_loop;
            w_rdata[28]              = w_armed;
            w_rdata[LGDEPTH+15:16]   = r_step;
            w_rdata[LGDEPTH:0]       = r_len;
         end
         2'd1: w_rdata[LGDEPTH:0] = r_len;
         2'd2: w_rdata = r_stage;
         default: begin
            w_rdata[HOLDW+LGDEPTH-1:HOLDW] = r_wptr;
            w_rdata[HOLDW-1:0]             = r_last_hold;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_ack   <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_ack <= wb.i_wb_cyc & wb.i_wb_stb;
         if (wb.i_wb_cyc && wb.i_wb_stb) r_rdata <= w_rdata;
      end
   end

   assign wb.o_wb_ack   = r_ack;
   assign wb.o_wb_stall = 1'b0;
   assign wb.o_wb_data  = r_rdata;
   assign o_gpio_stb    = w_gpio_stb;
   assign o_gpio_data   = r_rd_word;
   assign o_int         = r_int;

endmodule
